uart_cmd_parser: RTL and testbench

//  Downstream of the UART RX datapath/controller: consumes received bytes (one valid strobe per byte)
//  and parses framed commands: SYNC | ADDR | LEN | DATA[LEN] | CHK, where CHK = XOR(ADDR, LEN, DATA[*]).

---
 rtl/uart_cmd_parser_pkg.sv | 17 +
 rtl/uart_payload_buffer.sv | 27 ++
 rtl/uart_cmd_parser.sv | 174 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and helpers for the UART command parser slice.
package uart_cmd_parser_pkg;

  localparam int unsigned UART_WORD_SIZE     = 8;
  localparam int unsigned UART_MAX_PAYLOAD   = 16;
  // Roughly a dozen byte times at the nominal baud rate and system clock.
  localparam int unsigned UART_FRAME_TIMEOUT = 100000;
  localparam logic [7:0]  UART_SYNC_BYTE     = 8'hA5;

  typedef logic [7:0] wr_addr_t;

  // Counter/index width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_payload_buffer.sv
// Payload register file: synchronous write, combinational read, storage not reset.
module uart_payload_buffer
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC|ADDR|LEN|DATA[LEN]|CHK frames from the UART RX byte stream and drains the
// checked payload as addressed register writes with ready/valid backpressure.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned          WORD_SIZE      = UART_WORD_SIZE,
  parameter int unsigned          MAX_PAYLOAD    = UART_MAX_PAYLOAD,
  parameter int unsigned          TIMEOUT_CYCLES = UART_FRAME_TIMEOUT,
  parameter logic [WORD_SIZE-1:0] SYNC_BYTE      = WORD_SIZE'(UART_SYNC_BYTE)
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [WORD_SIZE-1:0] RX_Byte,
  input  logic                 RX_Byte_valid,
  output wr_addr_t             Wr_Addr,
  output logic [WORD_SIZE-1:0] Wr_Data,
  output logic                 Wr_Valid,
  input  logic                 Wr_Ready,
  output logic                 Frame_Done,
  output logic                 Chk_Err,
  output logic                 Len_Err,
  output logic                 Timeout_Err,
  output logic                 Overrun_Err,
  output logic                 Busy
);

  typedef enum logic [2:0] {StIdle, StAddr, StLen, StData, StChk, StDrain} state_e;

  localparam int unsigned          AW      = idx_width(MAX_PAYLOAD);
  localparam int unsigned          TW      = idx_width(TIMEOUT_CYCLES);
  localparam logic [WORD_SIZE-1:0] MaxLen  = WORD_SIZE'(MAX_PAYLOAD);
  localparam logic [WORD_SIZE-1:0] ByteOne = WORD_SIZE'(1);
  localparam logic [TW-1:0]        TmoLast = TW'(TIMEOUT_CYCLES - 1);

  state_e               state_q;
  wr_addr_t             addr_q;
  logic [AW-1:0]        idx_q;
  logic [AW-1:0]        last_q;
  logic [WORD_SIZE-1:0] chk_q;
  logic [TW-1:0]        tmo_q;

  logic                 buf_we;
  logic [AW-1:0]        buf_raddr;
  logic [WORD_SIZE-1:0] buf_rdata;

  // Read one entry ahead while draining so the registered Wr_Data is ready at acceptance.
  always_comb begin
    buf_we    = (state_q == StData) && RX_Byte_valid;
    buf_raddr = (state_q == StDrain) ? idx_q + AW'(1) : '0;
    Busy      = (state_q != StIdle);
  end

  uart_payload_buffer #(
    .DEPTH (MAX_PAYLOAD),
    .WIDTH (WORD_SIZE),
    .AW    (AW)
  ) u_payload_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (RX_Byte),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      Wr_Addr     <= '0;
      Wr_Data     <= '0;
      Wr_Valid    <= 1'b0;
      Frame_Done  <= 1'b0;
      Chk_Err     <= 1'b0;
      Len_Err     <= 1'b0;
      Timeout_Err <= 1'b0;
      Overrun_Err <= 1'b0;
    end else begin
      Frame_Done  <= 1'b0;
      Chk_Err     <= 1'b0;
      Len_Err     <= 1'b0;
      Timeout_Err <= 1'b0;
      Overrun_Err <= 1'b0;

      // Expiry only acts on byte-free cycles, so a byte arriving on the expiry cycle wins.
      if (state_q inside {StAddr, StLen, StData, StChk}) begin
        if (RX_Byte_valid) begin
          tmo_q <= '0;
        end else if (tmo_q == TmoLast) begin
          tmo_q       <= '0;
          Timeout_Err <= 1'b1;
          state_q     <= StIdle;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end else begin
        tmo_q <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (RX_Byte_valid && (RX_Byte == SYNC_BYTE)) begin
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (RX_Byte_valid) begin
            addr_q  <= wr_addr_t'(RX_Byte);
            chk_q   <= RX_Byte;
            state_q <= StLen;
          end
        end
        StLen: begin
          if (RX_Byte_valid) begin
            if ((RX_Byte != '0) && (RX_Byte <= MaxLen)) begin
              last_q  <= AW'(RX_Byte - ByteOne);
              chk_q   <= chk_q ^ RX_Byte;
              idx_q   <= '0;
              state_q <= StData;
            end else begin
              Len_Err <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StData: begin
          if (RX_Byte_valid) begin
            chk_q <= chk_q ^ RX_Byte;
            idx_q <= idx_q + AW'(1);
            if (idx_q == last_q) begin
              state_q <= StChk;
            end
          end
        end
        StChk: begin
          if (RX_Byte_valid) begin
            if (RX_Byte == chk_q) begin
              idx_q    <= '0;
              Wr_Valid <= 1'b1;
              Wr_Addr  <= addr_q;
              Wr_Data  <= buf_rdata;
              state_q  <= StDrain;
            end else begin
              Chk_Err <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StDrain: begin
          if (RX_Byte_valid) begin
            Overrun_Err <= 1'b1;
          end
          if (Wr_Ready) begin
            if (idx_q == last_q) begin
              Wr_Valid   <= 1'b0;
              Frame_Done <= 1'b1;
              state_q    <= StIdle;
            end else begin
              idx_q   <= idx_q + AW'(1);
              Wr_Addr <= Wr_Addr + wr_addr_t'(1);
              Wr_Data <= buf_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed frames plus randomized traffic.
module tb_uart_cmd_parser;

  localparam int unsigned TMO  = 64;
  localparam int unsigned MAXP = 16;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic       clk;
  logic       reset_b;
  logic [7:0] RX_Byte;
  logic       RX_Byte_valid;
  logic [7:0] Wr_Addr;
  logic [7:0] Wr_Data;
  logic       Wr_Valid;
  logic       Wr_Ready;
  logic       Frame_Done;
  logic       Chk_Err;
  logic       Len_Err;
  logic       Timeout_Err;
  logic       Overrun_Err;
  logic       Busy;

  uart_cmd_parser #(
    .WORD_SIZE      (8),
    .MAX_PAYLOAD    (MAXP),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_BYTE      (SYNC)
  ) dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .RX_Byte       (RX_Byte),
    .RX_Byte_valid (RX_Byte_valid),
    .Wr_Addr       (Wr_Addr),
    .Wr_Data       (Wr_Data),
    .Wr_Valid      (Wr_Valid),
    .Wr_Ready      (Wr_Ready),
    .Frame_Done    (Frame_Done),
    .Chk_Err       (Chk_Err),
    .Len_Err       (Len_Err),
    .Timeout_Err   (Timeout_Err),
    .Overrun_Err   (Overrun_Err),
    .Busy          (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          compared;
  int          mismatched;
  int          cyc;
  bit          rand_rdy;
  logic [15:0] wq[$];      // expected {addr, data} writes in order
  int          acc_t[$];   // cycle stamps of accepted writes
  int          exp_cnt[5]; // expected pulses: done, chk, len, timeout, overrun
  logic [7:0]  pl[$];      // payload of the frame being built
  string       pname[5] = '{"frame_done", "chk_err", "len_err", "timeout_err", "overrun_err"};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    compared++;
    mismatched++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a pulse.
  initial begin : monitor
    bit          hold;
    logic [15:0] held;
    logic [15:0] e;
    logic [4:0]  p;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_b) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("wr_valid_held", {31'd0, Wr_Valid}, 32'd1);
        check("wr_stable_stalled", {16'd0, Wr_Addr, Wr_Data}, {16'd0, held});
      end
      hold = 1'b0;
      if (Wr_Valid) begin
        if (Wr_Ready) begin
          acc_t.push_back(cyc);
          if (wq.size() == 0) begin
            fail_now("unexpected_write", $sformatf("got %02h,%02h, expected none", Wr_Addr, Wr_Data));
          end else begin
            e = wq.pop_front();
            check("write", {16'd0, Wr_Addr, Wr_Data}, {16'd0, e});
          end
        end else begin
          hold = 1'b1;
          held = {Wr_Addr, Wr_Data};
        end
      end
      p = {Overrun_Err, Timeout_Err, Len_Err, Chk_Err, Frame_Done};
      for (int k = 0; k < 5; k++) begin
        if (p[k]) begin
          if (exp_cnt[k] == 0) begin
            fail_now(pname[k], "pulse seen, expected none");
          end else begin
            compared++;
            exp_cnt[k]--;
          end
        end
      end
    end
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) Wr_Ready = 1'($urandom_range(0, 1));
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    RX_Byte       = b;
    RX_Byte_valid = 1'b1;
    @(posedge clk);
    #1;
    RX_Byte_valid = 1'b0;
    RX_Byte       = 8'($urandom);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: expected response of a whole frame from the framing rules.
  task automatic frame_send(input logic [7:0] a, input logic [7:0] n, input logic [7:0] flip,
                            input int gmax);
    logic [7:0] c;
    if ((n == 0) || (n > MAXP)) begin
      exp_cnt[2]++;
      send(SYNC, $urandom_range(0, gmax));
      send(a, $urandom_range(0, gmax));
      send(n, 0);
      return;
    end
    c = a ^ n;
    foreach (pl[i]) c ^= pl[i];
    c ^= flip;
    if (flip != 0) begin
      exp_cnt[1]++;
    end else begin
      foreach (pl[i]) wq.push_back({a + 8'(i), pl[i]});
      exp_cnt[0]++;
    end
    send(SYNC, $urandom_range(0, gmax));
    send(a, $urandom_range(0, gmax));
    send(n, $urandom_range(0, gmax));
    foreach (pl[i]) send(pl[i], $urandom_range(0, gmax));
    send(c, 0);
  endtask

  task automatic finish_frame(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (!Busy) break;
      step(1);
    end
    if (i == 3000) fail_now({name, "_idle"}, "Busy never fell");
    step(3);
    check({name, "_busy_low"}, {31'd0, Busy}, 32'd0);
    check({name, "_writes_left"}, wq.size(), 32'd0);
    for (int k = 0; k < 5; k++) check({name, "_", pname[k], "_left"}, exp_cnt[k], 32'd0);
  endtask

  task automatic reset_pulse(input string name);
    reset_b = 1'b0;
    step(1);
    reset_b = 1'b1;
    wq.delete();
    for (int k = 0; k < 5; k++) exp_cnt[k] = 0;
    check({name, "_outs"}, {16'd0, Wr_Addr, Wr_Data}, 32'd0);
    check({name, "_flags"},
          {25'd0, Wr_Valid, Frame_Done, Chk_Err, Len_Err, Timeout_Err, Overrun_Err, Busy}, 32'd0);
  endtask

  task automatic set_payload2(input logic [7:0] d0, input logic [7:0] d1);
    pl.delete();
    pl.push_back(d0);
    pl.push_back(d1);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] a;
    logic [7:0] n;
    logic [7:0] flip;
    int         sel;
    compared      = 0;
    mismatched    = 0;
    rand_rdy      = 1'b0;
    reset_b       = 1'b0;
    RX_Byte       = 8'h00;
    RX_Byte_valid = 1'b0;
    Wr_Ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_b = 1'b1;
    check("reset_outs", {16'd0, Wr_Addr, Wr_Data}, 32'd0);
    check("reset_flags",
          {25'd0, Wr_Valid, Frame_Done, Chk_Err, Len_Err, Timeout_Err, Overrun_Err, Busy}, 32'd0);

    // Basic frame, ready held high: back-to-back writes.
    Wr_Ready = 1'b1;
    set_payload2(8'h11, 8'h22);
    acc_t.delete();
    frame_send(8'h10, 8'd2, 8'h00, 0);
    check("first_valid_latency", {31'd0, Wr_Valid}, 32'd1);
    finish_frame("basic");
    check("basic_accepts", acc_t.size(), 32'd2);
    if (acc_t.size() == 2) check("basic_back_to_back", acc_t[1] - acc_t[0], 32'd1);

    // Address wrap.
    set_payload2(8'hAA, 8'hBB);
    frame_send(8'hFF, 8'd2, 8'h00, 1);
    finish_frame("wrap");

    // Bad checksum (sends 20 instead of 21), then bad lengths.
    set_payload2(8'h11, 8'h22);
    frame_send(8'h10, 8'd2, 8'h01, 0);
    finish_frame("chk_err");
    pl.delete();
    frame_send(8'h10, 8'h00, 8'h00, 0);
    finish_frame("len_zero");
    frame_send(8'h10, 8'h11, 8'h00, 0);
    finish_frame("len_big");

    // Inter-byte timeout mid-frame, then a good frame.
    send(SYNC, 0);
    send(8'h10, 0);
    send(8'h02, 0);
    send(8'h11, 0);
    exp_cnt[3]++;
    step(TMO - 4);
    check("busy_before_timeout", {31'd0, Busy}, 32'd1);
    check("timeout_not_early", exp_cnt[3], 32'd1);
    finish_frame("timeout");
    set_payload2(8'h11, 8'h22);
    frame_send(8'h10, 8'd2, 8'h00, 2);
    finish_frame("after_timeout");

    // Stalled drain with overrun bytes (including SYNC) dropped.
    Wr_Ready = 1'b0;
    set_payload2(8'h11, 8'h22);
    frame_send(8'h10, 8'd2, 8'h00, 0);
    step(5);
    exp_cnt[4]++;
    send(8'h55, 3);
    exp_cnt[4]++;
    send(SYNC, 10);
    check("stall_busy", {31'd0, Busy}, 32'd1);
    check("stall_no_writes", wq.size(), 32'd2);
    check("stall_head", {16'd0, Wr_Addr, Wr_Data}, 32'h1011);
    Wr_Ready = 1'b1;
    finish_frame("overrun");

    // Reset mid-DATA and mid-DRAIN, then garbage and a fresh frame.
    send(SYNC, 0);
    send(8'h10, 0);
    send(8'h04, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    reset_pulse("reset_data");
    Wr_Ready = 1'b0;
    set_payload2(8'h11, 8'h22);
    frame_send(8'h10, 8'd2, 8'h00, 0);
    step(2);
    reset_pulse("reset_drain");
    Wr_Ready = 1'b1;
    send(8'h00, 1);
    send(8'hFF, 1);
    set_payload2(8'h33, 8'h44);
    frame_send(8'h20, 8'd2, 8'h00, 1);
    finish_frame("after_reset");

    // Randomized frames with random backpressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      a    = 8'($urandom);
      sel  = $urandom_range(0, 9);
      flip = 8'h00;
      pl.delete();
      if (sel == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXP + 1, 255));
      end else begin
        n = 8'($urandom_range(1, MAXP));
        for (int i = 0; i < int'(n); i++) pl.push_back(8'($urandom));
        if (sel == 1) flip = 8'($urandom_range(1, 255));
      end
      frame_send(a, n, flip, 3);
      finish_frame("random");
    end
    rand_rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
